clk_ratio_meter: RTL
====================

CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on i_div_clk (min 2).
REQ-002 SHALL have parameter LOCK_COUNT, default 4, consecutive identical ratios required for lock (range 2..15).
REQ-003 SHALL have port i_ref_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_meas_en  input  1  synchronous measurement enable.
REQ-006 SHALL have port i_div_clk  input  1  measured clock, asynchronous to i_ref_clk.
REQ-007 SHALL have port o_ratio  output  8  last measured period, in i_ref_clk cycles.
REQ-008 SHALL have port o_high_cnt  output  8  last measured high time, in i_ref_clk cycles.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse per completed measurement.
REQ-010 SHALL have port o_locked  output  1  ratio stable for LOCK_COUNT measurements.
REQ-011 SHALL have port o_timeout  output  1  no rising edge within 255 cycles; sticky.

Function
REQ-012 SHALL synchronize i_div_clk through SYNC_STAGES flops; rise = synced high and previous synced low; fall = the reverse.
REQ-013 SHALL implement FSM IDLE, ARM, MEASURE: IDLE->ARM when i_meas_en=1; ARM->MEASURE on first rise (no o_valid); MEASURE stays on rise; any state->IDLE when i_meas_en=0.
REQ-014 SHALL load the 8-bit period counter with 1 on each rise; otherwise increment it, saturating at 255.
REQ-015 SHALL, on a rise in MEASURE, register o_ratio = period counter value and o_high_cnt = high counter value, and pulse o_valid for one cycle on the following cycle.
REQ-016 SHALL load the high counter with 1 on each rise, increment it while synced input is high, hold it from fall until the next rise, and saturate at 255.
REQ-017 SHALL report o_ratio = N for a steady divide-by-N input, N in 2..255.
REQ-018 SHALL, in MEASURE with period counter = 255 and no rise, set o_timeout, clear o_locked and the match counter, and go to ARM; a rise at count 255 SHALL be a valid measurement with o_ratio = 255.
REQ-019 SHALL clear o_timeout on the next o_valid or when i_meas_en=0.
REQ-020 SHALL compare each new ratio with the previous one: equal -> increment match counter (saturating); unequal -> reset it to 1; o_locked = match counter >= LOCK_COUNT, updated in the same cycle as o_valid.
REQ-021 SHALL give i_meas_en=0 priority over a simultaneous rise: no o_valid; o_locked, o_timeout, and the match counter cleared; o_ratio and o_high_cnt held.

Reset
REQ-022 SHALL, while i_rst=1, force FSM to IDLE, all counters and synchronizer flops to 0, and o_ratio, o_high_cnt, o_valid, o_locked, o_timeout to 0, independent of i_ref_clk.
REQ-023 SHALL, after i_rst falls mid-period, discard the partial period: the first o_valid requires two fresh rises.

Configuration
REQ-024 SHALL compile the high-time counter and o_high_cnt logic only when macro CLK_RATIO_DUTY_EN is defined.
REQ-025 SHALL, without CLK_RATIO_DUTY_EN, tie o_high_cnt to 0; all other behaviour unchanged.

Structure
REQ-026 SHALL put the FSM state type, CNT_W=8, and CNT_MAX=255 in shared package clk_meter_pkg.
REQ-027 SHALL implement the synchronizer as sub-module bit_sync, parameterised by SYNC_STAGES, with i_ref_clk and i_rst.

Verification
REQ-028 SHALL cover reset: i_rst=1 with i_div_clk toggling -> all outputs 0, o_valid never pulses.
REQ-029 SHALL cover divide-by-4 (2 high/2 low), i_meas_en=1 -> first o_valid after second rise, o_ratio=4, o_high_cnt=2; o_locked=1 at the 4th o_valid.
REQ-030 SHALL cover divide-by-5 (3 high/2 low) -> o_ratio=5; o_high_cnt=3 with CLK_RATIO_DUTY_EN, 0 without.
REQ-031 SHALL cover lock loss: locked at ratio 4, switch to ratio 6 -> o_locked=0 with the first o_ratio=6 pulse, and o_locked=1 again at the 4th consecutive 6.
REQ-032 SHALL cover timeout: stop i_div_clk low for 300 cycles -> o_timeout=1, o_locked=0; restart at ratio 8 -> o_timeout clears with the first o_valid, o_ratio=8.
REQ-033 SHALL cover abort: drop i_meas_en, or pulse i_rst, mid-period -> no o_valid for that period; o_locked=0; o_ratio held (i_meas_en) or 0 (i_rst).

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock ratio meter.
package clk_meter_pkg;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
    localparam logic [CNT_W-1:0] CNT_ONE = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction
endpackage

// File: rtl/clk_ratio_meter_sync.sv
// Multi-flop synchronizer bringing the measured clock into the i_ref_clk domain.
module bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_ref_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/clk_ratio_meter.sv
// Measures i_div_clk period (and optionally high time) in i_ref_clk cycles, with lock and timeout.
// Optional duty measurement is compiled in only when CLK_RATIO_DUTY_EN is defined.
module clk_ratio_meter
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_meas_en,
    input  logic             i_div_clk,
    output logic [CNT_W-1:0] o_ratio,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_timeout
);
    localparam logic [3:0] MATCH_MAX = 4'hF;

    state_t           r_state;
    logic             w_sync;
    logic             r_prev;
    logic             w_rise;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_ratio;
    logic             r_valid;
    logic             r_locked;
    logic             r_timeout;
    logic [3:0]       r_match;
    logic [3:0]       w_match_nxt;

    bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_ref_clk (i_ref_clk),
        .i_rst     (i_rst),
        .i_d       (i_div_clk),
        .o_q       (w_sync)
    );

    assign w_rise = w_sync & ~r_prev;

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev   <= 1'b0;
            r_period <= '0;
        end else begin
            r_prev   <= w_sync;
            r_period <= w_rise ? CNT_ONE : sat_inc(r_period);
        end
    end

`ifdef CLK_RATIO_DUTY_EN
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_high_cnt;

    // Counts only while the synced input is high, so it freezes from the fall to the next rise.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst)       r_high <= '0;
        else if (w_rise) r_high <= CNT_ONE;
        else if (w_sync) r_high <= sat_inc(r_high);
    end

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst)                                        r_high_cnt <= '0;
        else if (i_meas_en && r_state == ST_MEASURE && w_rise) r_high_cnt <= r_high;
    end

    assign o_high_cnt = r_high_cnt;
`else
    assign o_high_cnt = '0;
`endif

    assign w_match_nxt = (r_period != r_ratio) ? 4'd1 :
                         (r_match == MATCH_MAX) ? r_match : r_match + 4'd1;

    // Disable wins over any simultaneous rise; ratio is held, status is cleared.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_ratio   <= '0;
            r_valid   <= 1'b0;
            r_locked  <= 1'b0;
            r_timeout <= 1'b0;
            r_match   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (!i_meas_en) begin
                r_state   <= ST_IDLE;
                r_locked  <= 1'b0;
                r_timeout <= 1'b0;
                r_match   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_ARM;
                    ST_ARM: begin
                        if (w_rise) r_state <= ST_MEASURE;
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            r_ratio   <= r_period;
                            r_valid   <= 1'b1;
                            r_timeout <= 1'b0;
                            r_match   <= w_match_nxt;
                            r_locked  <= (w_match_nxt >= 4'(LOCK_COUNT));
                        end else if (r_period == CNT_MAX) begin
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                            r_match   <= '0;
                            r_state   <= ST_ARM;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_ratio   = r_ratio;
    assign o_valid   = r_valid;
    assign o_locked  = r_locked;
    assign o_timeout = r_timeout;
endmodule
